memory_stage: RTL and testbench
===============================

// Module: memory_stage
// PURPOSE
//  RV32 MEM pipeline stage. Sits between EX and WRITEBACK.
//  Takes the EX/MEM bundle and runs loads/stores on a variable-latency data-memory req/ack port.
//  Drives the MEM/WB register (wb_*) that WRITEBACK consumes.
//  Stalls upstream while a memory access is outstanding.
// PARAMETERS
//  ACK_TIMEOUT  16  cycles in WAIT without dmem_ack before the access is aborted (>=2)
// PORTS
//  clock          in   1   clock
//  reset          in   1   reset, asynchronous, active-high
//  ex_valid       in   1   EX/MEM bundle valid
//  ex_alu_result  in   32  address (mem op) or result (non-mem op)
//  ex_store_data  in   32  rs2 value for stores
//  ex_funct3      in   3   access size/sign
//  ex_mem_read    in   1   load
//  ex_mem_write   in   1   store (mem_read and mem_write never both 1)
//  ex_regwrite    in   1   instruction writes rd
//  ex_rd          in   5   destination register
//  mem_stall      out  1   upstream must hold ex_* stable; high exactly while state==WAIT
//  dmem_req       out  1   request; held high until dmem_ack or timeout
//  dmem_we        out  1   1 = store
//  dmem_addr      out  32  word-aligned address {addr[31:2],2'b00}
//  dmem_wdata     out  32  lane-replicated store data
//  dmem_be        out  4   byte enables (all 1 for loads)
//  dmem_ack       in   1   access complete; dmem_rdata valid this cycle
//  dmem_rdata     in   32  load data word
//  wb_valid       out  1   MEM/WB bundle valid
//  wb_regwrite    out  1   write wb_result to wb_rd
//  wb_rd          out  5   destination register
//  wb_result      out  32  ALU result or formatted load data
//  misalign       out  1   1-cycle pulse: misaligned or illegal funct3 mem op
//  bus_err        out  1   1-cycle pulse: access timed out
// BEHAVIOUR
//  Reset (async):
//   - state=IDLE; timeout counter=0.
//   - Every output and every captured register = 0.
//   - A dmem_ack arriving after reset is ignored.
//  FSM states: IDLE, WAIT. ex_* sampled only on edges where state==IDLE.
//  IDLE, ex_valid=0:
//   - wb_valid<=0, wb_regwrite<=0.
//  IDLE, non-mem op:
//   - wb_valid<=1; wb_result<=ex_alu_result; wb_rd<=ex_rd.
//   - wb_regwrite<=ex_regwrite & (ex_rd!=0).
//   - Latency 1.
//  IDLE, mem op legal and aligned:
//   - Capture address, funct3, rd, regwrite, formatted wdata/be.
//   - Next state WAIT; wb_valid<=0.
//  Alignment:
//   - H needs addr[0]==0; W needs addr[1:0]==0.
//   - Legal load funct3 = 000,001,010,100,101. Legal store funct3 = 000,001,010.
//  IDLE, mem op misaligned or illegal:
//   - No request issued.
//   - wb_valid<=1, wb_regwrite<=0, misalign<=1 for one cycle.
//  WAIT:
//   - dmem_req=1, dmem_we/addr/wdata/be stable from captured registers.
//   - Counter increments each cycle.
//  WAIT & dmem_ack:
//   - Next state IDLE; req drops next cycle; wb_valid<=1.
//   - Load: wb_result<=formatted rdata; wb_regwrite<=cap_regwrite & (cap_rd!=0).
//   - Store: wb_regwrite<=0.
//   - Latency: load result visible on wb_* the cycle after ack.
//  WAIT, counter==ACK_TIMEOUT-1, no ack:
//   - Next state IDLE; bus_err<=1 one cycle.
//   - wb_valid<=1, wb_regwrite<=0.
//   - If ack arrives on that same cycle, ack wins and there is no bus_err.
//  dmem_ack in IDLE is ignored. Counter clears on every entry to WAIT.
//  Load formatting (lane = addr[1:0]):
//   - LB/LBU: byte lane, sign/zero extended.
//   - LH/LHU: half at addr[1], sign/zero extended.
//   - LW: whole word.
//  Store formatting:
//   - SB: wdata={4{b}}, be=1<<addr[1:0].
//   - SH: wdata={2{h}}, be=addr[1]?4'b1100:4'b0011.
//   - SW: be=4'b1111.
//  Back-to-back: a new op is accepted on the first IDLE edge after WAIT exits; no bubble beyond that.
// STRUCTURE
//  Shared package riscv_pkg:
//   - funct3 constants (F3_B/H/W/BU/HU).
//   - mem_state_t enum {IDLE,WAIT}.
//  Sub-module lsu_align: combinational; store lane/be generation and load extract/extend.
//  FSM, counter and MEM/WB register stay in memory_stage.
// TESTING
//  ALU op ex_alu_result=0x1234, rd=5, regwrite=1 -> next cycle wb_valid=1, wb_rd=5, wb_result=0x1234, mem_stall never high.
//  LB addr=0x103, rdata=0x80FF_FF7F, ack after 3 WAIT cycles:
//   -> req high 3 cycles, be=4'hF, dmem_addr=0x100, wb_result=0xFFFF_FF80.
//  SH addr=0x202, store_data=0xABCD -> wdata=0xABCD_ABCD, be=4'b1100, wb_valid=1 & wb_regwrite=0 after ack.
//  LW addr=0x101 -> no dmem_req, misalign pulse 1 cycle, wb_regwrite=0, mem_stall stays 0.
//  Store with no ack:
//   -> bus_err pulses after exactly ACK_TIMEOUT WAIT cycles, state IDLE.
//   -> a late dmem_ack in IDLE causes no wb_valid.
//  reset asserted mid-WAIT -> dmem_req and mem_stall drop immediately (async), all wb_* = 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the MEM stage.
// Contents:
//   F3_*        load/store funct3 encodings (size and sign)
//   mem_state_t MEM-stage FSM state
//   mem_op_ok   checks funct3 legality and natural alignment of a memory op
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {IDLE, WAIT} mem_state_t;

    // Unsigned variants exist only for loads; halves and words must be naturally aligned.
    function automatic logic mem_op_ok(input logic [2:0] funct3, input logic [1:0] addr_lo,
                                       input logic is_store);
        logic ok;
        case (funct3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = ~addr_lo[0];
            F3_W:    ok = (addr_lo == 2'b00);
            F3_BU:   ok = ~is_store;
            F3_HU:   ok = ~is_store & ~addr_lo[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Data-memory request/acknowledge bus.
// Signals:
//   req    request, held until ack or abort     (master -> slave)
//   we     1 = store                            (master -> slave)
//   addr   word-aligned byte address            (master -> slave)
//   wdata  lane-replicated store data           (master -> slave)
//   be     byte enables                         (master -> slave)
//   ack    access complete, rdata valid         (slave -> master)
//   rdata  load data word                       (slave -> master)
interface memory_stage_if;

    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, we, addr, wdata, be, input ack, rdata);
    modport slave  (input req, we, addr, wdata, be, output ack, rdata);

endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane logic for the MEM stage.
// Ports:
//   st_funct3, st_addr_lo, st_data -> st_wdata, st_be   store replication and byte enables
//   ld_funct3, ld_addr_lo, ld_rdata -> ld_result        load extract and sign/zero extend
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_addr_lo,
    input  logic [31:0] st_data,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_result
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_wdata = st_data;
        st_be    = 4'b1111;
        case (st_funct3)
            F3_B: begin
                st_wdata = {4{st_data[7:0]}};
                st_be    = 4'b0001 << st_addr_lo;
            end
            F3_H: begin
                st_wdata = {2{st_data[15:0]}};
                st_be    = st_addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte   = ld_rdata[{ld_addr_lo, 3'b000} +: 8];
        ld_half   = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];
        ld_result = ld_rdata;
        case (ld_funct3)
            F3_B:    ld_result = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   ld_result = {24'b0, ld_byte};
            F3_H:    ld_result = {{16{ld_half[15]}}, ld_half};
            F3_HU:   ld_result = {16'b0, ld_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// RV32 MEM pipeline stage between EX and WRITEBACK.
// Ports:
//   clock, reset          clock; asynchronous active-high reset
//   ex_*                  EX/MEM bundle, sampled only while IDLE
//   mem_stall             holds upstream while an access is outstanding
//   dmem                  data-memory req/ack bus (master side)
//   wb_*                  MEM/WB register consumed by WRITEBACK
//   misalign, bus_err     one-cycle exception pulses
module memory_stage
    import riscv_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ex_valid,
    input  logic [31:0]           ex_alu_result,
    input  logic [31:0]           ex_store_data,
    input  logic [2:0]            ex_funct3,
    input  logic                  ex_mem_read,
    input  logic                  ex_mem_write,
    input  logic                  ex_regwrite,
    input  logic [4:0]            ex_rd,
    output logic                  mem_stall,
    memory_stage_if.master        dmem,
    output logic                  wb_valid,
    output logic                  wb_regwrite,
    output logic [4:0]            wb_rd,
    output logic [31:0]           wb_result,
    output logic                  misalign,
    output logic                  bus_err
);

    localparam int unsigned CntW = $clog2(ACK_TIMEOUT);

    mem_state_t  state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic [31:0] cap_addr_q, cap_addr_d;
    logic [2:0]  cap_funct3_q, cap_funct3_d;
    logic [4:0]  cap_rd_q, cap_rd_d;
    logic        cap_regwrite_q, cap_regwrite_d;
    logic        cap_we_q, cap_we_d;
    logic [31:0] cap_wdata_q, cap_wdata_d;
    logic [3:0]  cap_be_q, cap_be_d;

    logic        wb_valid_d, wb_regwrite_d;
    logic [4:0]  wb_rd_d;
    logic [31:0] wb_result_d;
    logic        misalign_d, bus_err_d;

    logic [31:0] st_wdata, ld_result;
    logic [3:0]  st_be;
    logic        is_mem, op_ok;

    lsu_align u_lsu_align (
        .st_funct3  (ex_funct3),
        .st_addr_lo (ex_alu_result[1:0]),
        .st_data    (ex_store_data),
        .st_wdata   (st_wdata),
        .st_be      (st_be),
        .ld_funct3  (cap_funct3_q),
        .ld_addr_lo (cap_addr_q[1:0]),
        .ld_rdata   (dmem.rdata),
        .ld_result  (ld_result)
    );

    assign is_mem = ex_mem_read | ex_mem_write;
    assign op_ok  = mem_op_ok(ex_funct3, ex_alu_result[1:0], ex_mem_write);

    // Decoded straight from state so an async reset drops them immediately.
    assign mem_stall  = (state_q == WAIT);
    assign dmem.req   = (state_q == WAIT);
    assign dmem.we    = cap_we_q;
    assign dmem.addr  = {cap_addr_q[31:2], 2'b00};
    assign dmem.wdata = cap_wdata_q;
    assign dmem.be    = cap_be_q;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        cap_addr_d     = cap_addr_q;
        cap_funct3_d   = cap_funct3_q;
        cap_rd_d       = cap_rd_q;
        cap_regwrite_d = cap_regwrite_q;
        cap_we_d       = cap_we_q;
        cap_wdata_d    = cap_wdata_q;
        cap_be_d       = cap_be_q;
        wb_valid_d     = wb_valid;
        wb_regwrite_d  = wb_regwrite;
        wb_rd_d        = wb_rd;
        wb_result_d    = wb_result;
        misalign_d     = 1'b0;
        bus_err_d      = 1'b0;

        case (state_q)
            IDLE: begin
                wb_valid_d    = 1'b0;
                wb_regwrite_d = 1'b0;
                if (ex_valid && !is_mem) begin
                    wb_valid_d    = 1'b1;
                    wb_result_d   = ex_alu_result;
                    wb_rd_d       = ex_rd;
                    wb_regwrite_d = ex_regwrite & (ex_rd != 5'd0);
                end else if (ex_valid && op_ok) begin
                    state_d        = WAIT;
                    cnt_d          = '0;
                    cap_addr_d     = ex_alu_result;
                    cap_funct3_d   = ex_funct3;
                    cap_rd_d       = ex_rd;
                    cap_regwrite_d = ex_regwrite;
                    cap_we_d       = ex_mem_write;
                    cap_wdata_d    = st_wdata;
                    cap_be_d       = ex_mem_write ? st_be : 4'b1111;
                end else if (ex_valid) begin
                    // Faulting op retires as a bubble with no register write.
                    wb_valid_d = 1'b1;
                    misalign_d = 1'b1;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + CntW'(1);
                if (dmem.ack) begin
                    state_d    = IDLE;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = cap_rd_q;
                    if (cap_we_q) begin
                        wb_regwrite_d = 1'b0;
                    end else begin
                        wb_result_d   = ld_result;
                        wb_regwrite_d = cap_regwrite_q & (cap_rd_q != 5'd0);
                    end
                end else if (cnt_q == CntW'(ACK_TIMEOUT - 1)) begin
                    state_d       = IDLE;
                    bus_err_d     = 1'b1;
                    wb_valid_d    = 1'b1;
                    wb_regwrite_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            cap_addr_q     <= '0;
            cap_funct3_q   <= '0;
            cap_rd_q       <= '0;
            cap_regwrite_q <= 1'b0;
            cap_we_q       <= 1'b0;
            cap_wdata_q    <= '0;
            cap_be_q       <= '0;
            wb_valid       <= 1'b0;
            wb_regwrite    <= 1'b0;
            wb_rd          <= '0;
            wb_result      <= '0;
            misalign       <= 1'b0;
            bus_err        <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            cap_addr_q     <= cap_addr_d;
            cap_funct3_q   <= cap_funct3_d;
            cap_rd_q       <= cap_rd_d;
            cap_regwrite_q <= cap_regwrite_d;
            cap_we_q       <= cap_we_d;
            cap_wdata_q    <= cap_wdata_d;
            cap_be_q       <= cap_be_d;
            wb_valid       <= wb_valid_d;
            wb_regwrite    <= wb_regwrite_d;
            wb_rd          <= wb_rd_d;
            wb_result      <= wb_result_d;
            misalign       <= misalign_d;
            bus_err        <= bus_err_d;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage.
module tb_memory_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ex_valid = 1'b0;
    logic [31:0] ex_alu_result = '0;
    logic [31:0] ex_store_data = '0;
    logic [2:0]  ex_funct3 = '0;
    logic        ex_mem_read = 1'b0;
    logic        ex_mem_write = 1'b0;
    logic        ex_regwrite = 1'b0;
    logic [4:0]  ex_rd = '0;
    logic        mem_stall;
    logic        wb_valid, wb_regwrite, misalign, bus_err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_result;

    int checks = 0;
    int failures = 0;
    int n;

    memory_stage_if dmem_bus ();

    memory_stage #(.ACK_TIMEOUT(16)) dut (
        .clock         (clock),
        .reset         (reset),
        .ex_valid      (ex_valid),
        .ex_alu_result (ex_alu_result),
        .ex_store_data (ex_store_data),
        .ex_funct3     (ex_funct3),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_regwrite   (ex_regwrite),
        .ex_rd         (ex_rd),
        .mem_stall     (mem_stall),
        .dmem          (dmem_bus),
        .wb_valid      (wb_valid),
        .wb_regwrite   (wb_regwrite),
        .wb_rd         (wb_rd),
        .wb_result     (wb_result),
        .misalign      (misalign),
        .bus_err       (bus_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] sd,
                         input logic [2:0] f3, input logic rd_en, input logic wr_en,
                         input logic rw, input logic [4:0] rd);
        ex_valid = v; ex_alu_result = a; ex_store_data = sd; ex_funct3 = f3;
        ex_mem_read = rd_en; ex_mem_write = wr_en; ex_regwrite = rw; ex_rd = rd;
    endtask

    initial begin
        dmem_bus.ack   = 1'b0;
        dmem_bus.rdata = '0;

        // Reset state
        #3;
        check("rst_req", dmem_bus.req, 0);
        check("rst_stall", mem_stall, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_wb_result", wb_result, 0);
        check("rst_be", dmem_bus.be, 0);
        check("rst_addr", dmem_bus.addr, 0);
        #9 reset = 1'b0;

        // ALU op, latency 1
        drive(1, 32'h1234, 0, 3'b000, 0, 0, 1, 5'd5);
        tick();
        check("alu_wb_valid", wb_valid, 1);
        check("alu_wb_rd", wb_rd, 5);
        check("alu_wb_result", wb_result, 32'h1234);
        check("alu_wb_regwrite", wb_regwrite, 1);
        check("alu_stall", mem_stall, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check("idle_wb_valid", wb_valid, 0);

        // LB 0x103, ack in third WAIT cycle
        drive(1, 32'h103, 0, 3'b000, 1, 0, 1, 5'd7);
        tick();
        check("lb_addr", dmem_bus.addr, 32'h100);
        check("lb_be", dmem_bus.be, 4'hF);
        check("lb_we", dmem_bus.we, 0);
        check("lb_stall", mem_stall, 1);
        n = 0;
        for (int i = 0; i < 3; i++) begin
            if (dmem_bus.req) n++;
            if (i < 2) tick();
        end
        dmem_bus.ack = 1'b1;
        dmem_bus.rdata = 32'h80FF_FF7F;
        ex_valid = 1'b0;
        tick();
        dmem_bus.ack = 1'b0;
        check("lb_req_cycles", n, 3);
        check("lb_wb_valid", wb_valid, 1);
        check("lb_wb_result", wb_result, 32'hFFFF_FF80);
        check("lb_wb_regwrite", wb_regwrite, 1);
        check("lb_wb_rd", wb_rd, 7);
        check("lb_req_drop", dmem_bus.req, 0);

        // SH 0x202, immediate ack
        drive(1, 32'h202, 32'h0000_ABCD, 3'b001, 0, 1, 0, 5'd0);
        tick();
        check("sh_wdata", dmem_bus.wdata, 32'hABCD_ABCD);
        check("sh_be", dmem_bus.be, 4'b1100);
        check("sh_we", dmem_bus.we, 1);
        check("sh_addr", dmem_bus.addr, 32'h200);
        dmem_bus.ack = 1'b1;
        ex_valid = 1'b0;
        tick();
        dmem_bus.ack = 1'b0;
        check("sh_wb_valid", wb_valid, 1);
        check("sh_wb_regwrite", wb_regwrite, 0);

        // LHU 0x106 into x0: upper half, zero extended, no regwrite
        drive(1, 32'h106, 0, 3'b101, 1, 0, 1, 5'd0);
        tick();
        dmem_bus.ack = 1'b1;
        dmem_bus.rdata = 32'h8001_1234;
        ex_valid = 1'b0;
        tick();
        dmem_bus.ack = 1'b0;
        check("lhu_wb_result", wb_result, 32'h0000_8001);
        check("lhu_wb_regwrite", wb_regwrite, 0);

        // Misaligned LW
        drive(1, 32'h101, 0, 3'b010, 1, 0, 1, 5'd3);
        tick();
        check("mis_pulse", misalign, 1);
        check("mis_req", dmem_bus.req, 0);
        check("mis_stall", mem_stall, 0);
        check("mis_wb_valid", wb_valid, 1);
        check("mis_wb_regwrite", wb_regwrite, 0);
        ex_valid = 1'b0;
        tick();
        check("mis_pulse_end", misalign, 0);

        // Illegal store funct3 (SBU)
        drive(1, 32'h100, 0, 3'b100, 0, 1, 0, 5'd0);
        tick();
        check("ill_pulse", misalign, 1);
        check("ill_req", dmem_bus.req, 0);
        ex_valid = 1'b0;
        tick();

        // SW with no ack: abort after 16 WAIT cycles
        drive(1, 32'h300, 32'hDEAD_BEEF, 3'b010, 0, 1, 0, 5'd0);
        tick();
        ex_valid = 1'b0;
        check("sw_wdata", dmem_bus.wdata, 32'hDEAD_BEEF);
        check("sw_be", dmem_bus.be, 4'hF);
        n = dmem_bus.req ? 1 : 0;
        while (dmem_bus.req && n < 40) begin
            tick();
            if (dmem_bus.req) n++;
        end
        check("to_wait_cycles", n, 16);
        check("to_bus_err", bus_err, 1);
        check("to_wb_valid", wb_valid, 1);
        check("to_wb_regwrite", wb_regwrite, 0);
        check("to_stall", mem_stall, 0);
        dmem_bus.ack = 1'b1;
        tick();
        dmem_bus.ack = 1'b0;
        check("late_ack_wb_valid", wb_valid, 0);
        check("bus_err_end", bus_err, 0);

        // SB 0x401, ack on the final timeout cycle wins
        drive(1, 32'h401, 32'h0000_005A, 3'b000, 0, 1, 0, 5'd0);
        tick();
        ex_valid = 1'b0;
        check("sb_wdata", dmem_bus.wdata, 32'h5A5A_5A5A);
        check("sb_be", dmem_bus.be, 4'b0010);
        repeat (15) tick();
        check("sb_req_last", dmem_bus.req, 1);
        dmem_bus.ack = 1'b1;
        tick();
        dmem_bus.ack = 1'b0;
        check("race_bus_err", bus_err, 0);
        check("race_wb_valid", wb_valid, 1);

        // Reset mid-WAIT
        drive(1, 32'h500, 0, 3'b010, 1, 0, 1, 5'd9);
        tick();
        check("pre_rst_req", dmem_bus.req, 1);
        #2 reset = 1'b1;
        #1;
        check("arst_req", dmem_bus.req, 0);
        check("arst_stall", mem_stall, 0);
        check("arst_wb_valid", wb_valid, 0);
        check("arst_wb_result", wb_result, 0);
        check("arst_wb_rd", wb_rd, 0);
        ex_valid = 1'b0;
        dmem_bus.ack = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        tick();
        dmem_bus.ack = 1'b0;
        check("post_rst_ack_ignored", wb_valid, 0);
        check("post_rst_req", dmem_bus.req, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
